// File: rtl/io_interrupt_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : io_interrupt_controller_if
//  Description : Keyboard, printer and CPU I/O-op signal bundle for the
//                interrupt controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface io_interrupt_controller_if #(
    parameter int DATA_W = 8
);
    logic              kbd_valid;
    logic [DATA_W-1:0] kbd_data;
    logic              kbd_ready;
    logic              prn_valid;
    logic [DATA_W-1:0] prn_data;
    logic              prn_ready;
    logic              cpu_op_valid;
    logic [2:0]        cpu_op;
    logic [DATA_W-1:0] cpu_ac;
    logic [DATA_W-1:0] inpr;
    logic              fgi;
    logic              fgo;
    logic              ien;
    logic              skip;
    logic              irq;
    logic              irq_ack;
    logic              ovr;

    // Environment side: keyboard, printer and CPU drivers.
    modport master (
        output kbd_valid, kbd_data, prn_ready, cpu_op_valid, cpu_op, cpu_ac,
               irq_ack,
        input  kbd_ready, prn_valid, prn_data, inpr, fgi, fgo, ien, skip,
               irq, ovr
    );

    // Controller side.
    modport slave (
        input  kbd_valid, kbd_data, prn_ready, cpu_op_valid, cpu_op, cpu_ac,
               irq_ack,
        output kbd_ready, prn_valid, prn_data, inpr, fgi, fgo, ien, skip,
               irq, ovr
    );
endinterface
`default_nettype wire

// File: rtl/io_interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : io_interrupt_controller
//  Description : Basic-computer style I/O flags, printer handshake FSM and
//                interrupt request generation.
//  Revision    : 1.0  initial release
// ============================================================================
module io_interrupt_controller #(
    parameter int DATA_W    = 8,
    parameter int PRN_DELAY = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    io_interrupt_controller_if.slave  bus
);

    localparam logic [2:0] c_OP_INP = 3'd0;
    localparam logic [2:0] c_OP_OUT = 3'd1;
    localparam logic [2:0] c_OP_SKI = 3'd2;
    localparam logic [2:0] c_OP_SKO = 3'd3;
    localparam logic [2:0] c_OP_ION = 3'd4;
    localparam logic [2:0] c_OP_IOF = 3'd5;

    localparam logic [7:0] c_BUSY_LOAD = 8'(PRN_DELAY - 1);

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_SEND = 2'd1,
        P_BUSY = 2'd2
    } prn_state_t;

    prn_state_t        state_q;
    logic [7:0]        cnt_q;
    logic              fgi_q;
    logic              fgo_q;
    logic              ien_q;
    logic              irq_q;
    logic              skip_q;
    logic              ovr_q;
    logic              prn_valid_q;
    logic [DATA_W-1:0] inpr_q;
    logic [DATA_W-1:0] prn_data_q;

    logic w_op_inp;
    logic w_op_out;
    logic w_op_ski;
    logic w_op_sko;
    logic w_op_ion;
    logic w_op_iof;
    logic w_kbd_accept;

    assign w_op_inp = bus.cpu_op_valid && (bus.cpu_op == c_OP_INP);
    assign w_op_out = bus.cpu_op_valid && (bus.cpu_op == c_OP_OUT);
    assign w_op_ski = bus.cpu_op_valid && (bus.cpu_op == c_OP_SKI);
    assign w_op_sko = bus.cpu_op_valid && (bus.cpu_op == c_OP_SKO);
    assign w_op_ion = bus.cpu_op_valid && (bus.cpu_op == c_OP_ION);
    assign w_op_iof = bus.cpu_op_valid && (bus.cpu_op == c_OP_IOF);

    assign w_kbd_accept = bus.kbd_valid && !fgi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= P_IDLE;
            cnt_q       <= 8'd0;
            fgi_q       <= 1'b0;
            fgo_q       <= 1'b1;
            ien_q       <= 1'b0;
            irq_q       <= 1'b0;
            skip_q      <= 1'b0;
            ovr_q       <= 1'b0;
            prn_valid_q <= 1'b0;
            inpr_q      <= '0;
            prn_data_q  <= '0;
        end else begin
            // A newly arriving character wins over INP so it is never lost.
            if (w_kbd_accept) begin
                inpr_q <= bus.kbd_data;
                fgi_q  <= 1'b1;
            end else if (w_op_inp) begin
                fgi_q <= 1'b0;
            end

            skip_q <= (w_op_ski && fgi_q) || (w_op_sko && fgo_q);

            if (bus.irq_ack) begin
                ien_q <= 1'b0;
            end else if (w_op_ion) begin
                ien_q <= 1'b1;
            end else if (w_op_iof) begin
                ien_q <= 1'b0;
            end

            irq_q <= !bus.irq_ack && ien_q && (fgi_q || fgo_q);

            if (w_op_out && (state_q != P_IDLE)) begin
                ovr_q <= 1'b1;
            end

            case (state_q)
                P_IDLE: begin
                    if (w_op_out) begin
                        prn_data_q  <= bus.cpu_ac;
                        fgo_q       <= 1'b0;
                        prn_valid_q <= 1'b1;
                        state_q     <= P_SEND;
                    end
                end
                P_SEND: begin
                    if (bus.prn_ready) begin
                        cnt_q       <= c_BUSY_LOAD;
                        prn_valid_q <= 1'b0;
                        state_q     <= P_BUSY;
                    end
                end
                P_BUSY: begin
                    if (cnt_q == 8'd0) begin
                        fgo_q   <= 1'b1;
                        state_q <= P_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    prn_valid_q <= 1'b0;
                    state_q     <= P_IDLE;
                end
            endcase
        end
    end

    assign bus.kbd_ready = ~fgi_q;
    assign bus.prn_valid = prn_valid_q;
    assign bus.prn_data  = prn_data_q;
    assign bus.inpr      = inpr_q;
    assign bus.fgi       = fgi_q;
    assign bus.fgo       = fgo_q;
    assign bus.ien       = ien_q;
    assign bus.skip      = skip_q;
    assign bus.irq       = irq_q;
    assign bus.ovr       = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_io_interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_interrupt_controller
//  Description : Directed scenarios plus randomized traffic against a
//                flag-level reference model of the I/O interrupt controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_io_interrupt_controller;

    localparam int DATA_W    = 8;
    localparam int PRN_DELAY = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    io_interrupt_controller_if #(.DATA_W(DATA_W)) bus ();

    io_interrupt_controller #(
        .DATA_W    (DATA_W),
        .PRN_DELAY (PRN_DELAY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the printer is idle exactly when fgo is set; while
    // fgo is clear a character is either still offered or counting down.
    logic        m_fgi, m_fgo, m_ien, m_irq, m_skip, m_ovr, m_offered;
    logic [7:0]  m_inpr, m_prn;
    int          m_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("fgi",       32'(bus.fgi),       32'(m_fgi));
        chk("fgo",       32'(bus.fgo),       32'(m_fgo));
        chk("ien",       32'(bus.ien),       32'(m_ien));
        chk("irq",       32'(bus.irq),       32'(m_irq));
        chk("skip",      32'(bus.skip),      32'(m_skip));
        chk("ovr",       32'(bus.ovr),       32'(m_ovr));
        chk("inpr",      32'(bus.inpr),      32'(m_inpr));
        chk("prn_data",  32'(bus.prn_data),  32'(m_prn));
        chk("prn_valid", 32'(bus.prn_valid), 32'(m_offered));
        chk("kbd_ready", 32'(bus.kbd_ready), 32'(!m_fgi));
    endtask

    // Advance one clock: compute the model's next state from the inputs
    // currently driven, then compare after the edge.
    task automatic cycle();
        logic       n_fgi, n_fgo, n_ien, n_irq, n_skip, n_ovr, n_off;
        logic [7:0] n_inpr, n_prn;
        int         n_left;
        logic       v;
        v = bus.cpu_op_valid;
        n_fgi = m_fgi; n_fgo = m_fgo; n_ien = m_ien; n_ovr = m_ovr;
        n_off = m_offered; n_inpr = m_inpr; n_prn = m_prn; n_left = m_left;
        if (rst) begin
            n_fgi = 0; n_fgo = 1; n_ien = 0; n_irq = 0; n_skip = 0; n_ovr = 0;
            n_off = 0; n_inpr = 0; n_prn = 0; n_left = 0;
        end else begin
            if (bus.kbd_valid && !m_fgi) begin
                n_inpr = bus.kbd_data;
                n_fgi  = 1;
            end else if (v && bus.cpu_op == 3'd0) begin
                n_fgi = 0;
            end
            n_skip = (v && bus.cpu_op == 3'd2 && m_fgi) || (v && bus.cpu_op == 3'd3 && m_fgo);
            if (bus.irq_ack)                    n_ien = 0;
            else if (v && bus.cpu_op == 3'd4)   n_ien = 1;
            else if (v && bus.cpu_op == 3'd5)   n_ien = 0;
            n_irq = !bus.irq_ack && m_ien && (m_fgi || m_fgo);
            if (m_fgo) begin
                if (v && bus.cpu_op == 3'd1) begin
                    n_prn = bus.cpu_ac;
                    n_fgo = 0;
                    n_off = 1;
                end
            end else begin
                if (v && bus.cpu_op == 3'd1) n_ovr = 1;
                if (m_offered) begin
                    if (bus.prn_ready) begin
                        n_off  = 0;
                        n_left = PRN_DELAY;
                    end
                end else begin
                    n_left = m_left - 1;
                    if (n_left == 0) n_fgo = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_fgi = n_fgi; m_fgo = n_fgo; m_ien = n_ien; m_irq = n_irq;
        m_skip = n_skip; m_ovr = n_ovr; m_offered = n_off; m_inpr = n_inpr;
        m_prn = n_prn; m_left = n_left;
        check_all();
    endtask

    task automatic idle_inputs();
        rst              = 1'b0;
        bus.kbd_valid    = 1'b0;
        bus.kbd_data     = '0;
        bus.prn_ready    = 1'b0;
        bus.cpu_op_valid = 1'b0;
        bus.cpu_op       = 3'd7;
        bus.cpu_ac       = '0;
        bus.irq_ack      = 1'b0;
    endtask

    task automatic op(input logic [2:0] code, input logic [7:0] ac);
        bus.cpu_op_valid = 1'b1;
        bus.cpu_op       = code;
        bus.cpu_ac       = ac;
    endtask

    task automatic no_op();
        bus.cpu_op_valid = 1'b0;
        bus.cpu_op       = 3'd7;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_fgi = 0; m_fgo = 1; m_ien = 0; m_irq = 0; m_skip = 0; m_ovr = 0;
        m_offered = 0; m_inpr = 0; m_prn = 0; m_left = 0;
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_fgo", 32'(bus.fgo), 32'd1);
        chk("reset_kbd_ready", 32'(bus.kbd_ready), 32'd1);
        rst = 1'b0;

        // Keyboard handshake and hold-off while fgi is set.
        bus.kbd_valid = 1'b1; bus.kbd_data = 8'h41;
        cycle();
        chk("kbd_first_inpr", 32'(bus.inpr), 32'h41);
        chk("kbd_first_ready", 32'(bus.kbd_ready), 32'd0);
        bus.kbd_data = 8'h42;
        cycle();
        chk("kbd_hold_inpr", 32'(bus.inpr), 32'h41);
        bus.kbd_valid = 1'b0;
        op(3'd0, 8'h00);
        cycle();
        chk("inp_clears_fgi", 32'(bus.fgi), 32'd0);
        no_op();
        bus.kbd_valid = 1'b1;
        cycle();
        chk("kbd_second_inpr", 32'(bus.inpr), 32'h42);
        bus.kbd_valid = 1'b0;
        op(3'd0, 8'h00);
        cycle();
        no_op();

        // Printer: three stalled SEND cycles, acceptance, then busy time.
        op(3'd1, 8'h5A);
        cycle();
        no_op();
        chk("out_valid", 32'(bus.prn_valid), 32'd1);
        chk("out_fgo", 32'(bus.fgo), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("send_hold_data", 32'(bus.prn_data), 32'h5A);
        end
        bus.prn_ready = 1'b1;
        cycle();
        bus.prn_ready = 1'b0;
        chk("send_accepted", 32'(bus.prn_valid), 32'd0);
        op(3'd1, 8'h11);
        cycle();
        no_op();
        chk("ovr_set", 32'(bus.ovr), 32'd1);
        chk("ovr_data_kept", 32'(bus.prn_data), 32'h5A);
        cycle();
        cycle();
        chk("busy_fgo_low", 32'(bus.fgo), 32'd0);
        cycle();
        chk("busy_fgo_done", 32'(bus.fgo), 32'd1);
        cycle();
        chk("ovr_sticky", 32'(bus.ovr), 32'd1);

        // Interrupt request and acknowledge priority over ION.
        op(3'd4, 8'h00);
        cycle();
        no_op();
        bus.kbd_valid = 1'b1; bus.kbd_data = 8'h77;
        cycle();
        bus.kbd_valid = 1'b0;
        cycle();
        chk("irq_raised", 32'(bus.irq), 32'd1);
        op(3'd4, 8'h00);
        bus.irq_ack = 1'b1;
        cycle();
        bus.irq_ack = 1'b0;
        no_op();
        chk("ack_ien", 32'(bus.ien), 32'd0);
        chk("ack_irq", 32'(bus.irq), 32'd0);

        // Skip pulses and no-op code.
        op(3'd2, 8'h00);
        cycle();
        no_op();
        chk("ski_skip", 32'(bus.skip), 32'd1);
        cycle();
        chk("skip_one_cycle", 32'(bus.skip), 32'd0);
        op(3'd1, 8'h33);
        cycle();
        op(3'd3, 8'h00);
        cycle();
        op(3'd6, 8'hFF);
        chk("sko_send_skip", 32'(bus.skip), 32'd0);
        cycle();
        no_op();
        bus.prn_ready = 1'b1;
        cycle();
        bus.prn_ready = 1'b0;
        op(3'd4, 8'h00);
        cycle();
        no_op();

        // Reset while busy with ien and fgi set.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_busy_fgo", 32'(bus.fgo), 32'd1);
        chk("rst_busy_ready", 32'(bus.kbd_ready), 32'd1);
        chk("rst_busy_ovr", 32'(bus.ovr), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] code;
            rst              = ($urandom_range(0, 299) == 0);
            bus.kbd_valid    = ($urandom_range(0, 3) == 0);
            bus.kbd_data     = 8'($urandom);
            bus.prn_ready    = ($urandom_range(0, 2) == 0);
            bus.irq_ack      = ($urandom_range(0, 15) == 0);
            bus.cpu_op_valid = ($urandom_range(0, 1) == 0);
            code             = 3'($urandom_range(0, 7));
            if (code == 3'd0 && !m_fgi) code = 3'd7;
            bus.cpu_op       = code;
            bus.cpu_ac       = 8'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_interrupt_controller.md
IO_INTERRUPT_CONTROLLER -- requirements
Module: io_interrupt_controller

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the width of the keyboard/printer character path.
REQ-002 The block SHALL have parameter PRN_DELAY, default 4, giving the printer busy time in cycles after character acceptance (legal range 1..255).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port kbd_valid  input  1  keyboard offers a character.
REQ-006 The block SHALL have port kbd_data  input  DATA_W  keyboard character.
REQ-007 The block SHALL have port kbd_ready  output  1  combinational, equal to ~fgi.
REQ-008 The block SHALL have port prn_valid  output  1  printer character offered.
REQ-009 The block SHALL have port prn_data  output  DATA_W  registered OUTR contents.
REQ-010 The block SHALL have port prn_ready  input  1  printer accepts the character.
REQ-011 The block SHALL have port cpu_op_valid  input  1  CPU issues an I/O op this cycle.
REQ-012 The block SHALL have port cpu_op  input  3  op code: 0=INP, 1=OUT, 2=SKI, 3=SKO, 4=ION, 5=IOF; 6 and 7 are no-ops.
REQ-013 The block SHALL have port cpu_ac  input  DATA_W  AC low bits for OUT.
REQ-014 The block SHALL have port inpr  output  DATA_W  registered INPR contents.
REQ-015 The block SHALL have ports fgi, fgo and ien  output  1 each  input flag, output flag and interrupt enable.
REQ-016 The block SHALL have port skip  output  1  registered one-cycle skip pulse to the CPU.
REQ-017 The block SHALL have port irq  output  1  registered interrupt request.
REQ-018 The block SHALL have port irq_ack  input  1  one-cycle pulse marking CPU entry into the interrupt cycle.
REQ-019 The block SHALL have port ovr  output  1  sticky overrun error.

Function
REQ-020 Keyboard handshake: kbd_valid & kbd_ready at an edge SHALL load inpr<=kbd_data and set fgi<=1; kbd_valid while fgi=1 SHALL be ignored, with no loss of the current inpr.
REQ-021 INP SHALL clear fgi at the next edge and leave inpr unchanged; kbd_ready therefore rises one cycle after the INP op, never in the INP cycle itself.
REQ-022 The printer FSM SHALL have states P_IDLE, P_SEND and P_BUSY.
REQ-023 In P_IDLE, OUT SHALL load prn_data<=cpu_ac, clear fgo and move to P_SEND.
REQ-024 In P_SEND, prn_valid SHALL be 1; on prn_ready the FSM SHALL load the busy counter with PRN_DELAY-1 and move to P_BUSY.
REQ-025 In P_BUSY, the counter SHALL decrement each cycle; when it reaches 0, fgo<=1 and the FSM SHALL return to P_IDLE.
REQ-026 prn_valid SHALL be 1 only in P_SEND; prn_data SHALL stay stable from the OUT edge until the P_SEND exit.
REQ-027 The OUT-to-fgo latency SHALL be 1 + (cycles waiting for prn_ready) + PRN_DELAY cycles.
REQ-028 OUT issued while not in P_IDLE SHALL be dropped (prn_data and fgo unchanged) and SHALL set ovr<=1; ovr SHALL clear only on rst.
REQ-029 SKI/SKO SHALL sample fgi/fgo in the op cycle and drive skip=sampled value for exactly the next cycle; all other cycles SHALL have skip=0.
REQ-030 ION SHALL set ien and IOF SHALL clear ien, at the next edge.
REQ-031 irq SHALL be registered as ien & (fgi | fgo), evaluated on current register values, so it lags a flag or ien change by one cycle.
REQ-032 irq_ack SHALL clear ien and irq at the next edge; it SHALL take priority over ION in the same cycle.
REQ-033 irq_ack while irq=0 SHALL still clear ien and SHALL have no other effect.
REQ-034 INP in the same cycle as a flag-setting event SHALL NOT occur, because kbd_ready=0 while fgi=1; the op SHALL then only clear fgi.
REQ-035 cpu_op values 6 and 7, and all ops with cpu_op_valid=0, SHALL change no state.

Reset
REQ-036 With rst=1 at an edge, the block SHALL set fgi=0, fgo=1, ien=0, irq=0, skip=0, ovr=0, inpr=0 and prn_data=0, put the FSM in P_IDLE with counter 0 and prn_valid=0; rst SHALL override all other inputs that cycle.
REQ-037 Reset mid-print (P_SEND or P_BUSY) SHALL abort the character, with fgo=1 immediately after the reset edge.

Verification
REQ-038 Scenario: kbd_valid=1, kbd_data=0x41 after reset -> inpr=0x41 and fgi=1 next cycle, and kbd_ready=0; a second kbd_data=0x42 while fgi=1 -> inpr stays 0x41; INP -> fgi=0 next cycle, then 0x42 is accepted.
REQ-039 Scenario: OUT with cpu_ac=0x5A and prn_ready held 0 for 3 cycles then 1 -> prn_valid high 4 cycles with prn_data=0x5A, fgo=0, and fgo=1 exactly PRN_DELAY=4 cycles after acceptance.
REQ-040 Scenario: second OUT with cpu_ac=0x11 while in P_BUSY -> prn_data stays 0x5A, ovr=1 and stays 1 until rst.
REQ-041 Scenario: ION then a keyboard char -> irq=1 one cycle after fgi=1; irq_ack together with ION -> ien=0 and irq=0 next cycle.
REQ-042 Scenario: SKI with fgi=1 -> skip=1 for one cycle; SKO during P_SEND -> skip=0; op 6 -> no state change.
REQ-043 Scenario: rst asserted in P_BUSY with ien=1 and fgi=1 -> all outputs at reset values next cycle and fgo=1, kbd_ready=1.
